// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: framebuffer-to-VGA pixel fetch with integer scaling, RAM latency alignment and tear-free frame gating
// Ports:
//   vga_clk     pixel clock
//   reset_n     asynchronous active-low reset
//   enable      output request, acted on only at frame start
//   hcount      current pixel column from the timing generator
//   vcount      current line from the timing generator
//   addr        registered framebuffer read address
//   data        RAM read data, valid RAM_LATENCY cycles after addr
//   vga_r/g/b   registered colour outputs, black when not valid
//   pix_valid   colour outputs carry framebuffer data this cycle
//   frame_done  one-cycle pulse after the last active pixel of a frame is output
module vga_pixel_fetch #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SCALE_SHIFT   = 0,
  parameter int FB_WIDTH      = SCREEN_WIDTH >> SCALE_SHIFT,
  parameter int FB_HEIGHT     = SCREEN_HEIGHT >> SCALE_SHIFT,
  parameter int ADDR_WIDTH    = 19,
  parameter int DATA_WIDTH    = 24,
  parameter int RAM_LATENCY   = 1,
  parameter int COLOR_DEPTH   = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [COLOR_DEPTH-1:0] vga_r,
  output logic [COLOR_DEPTH-1:0] vga_g,
  output logic [COLOR_DEPTH-1:0] vga_b,
  output logic                   pix_valid,
  output logic                   frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state;
  logic act, fstart, last, live;
  logic [RAM_LATENCY:0] vpipe;
  logic [RAM_LATENCY+1:0] lpipe;
  logic [7:0] r8, g8, b8;

  if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || FB_WIDTH * FB_HEIGHT > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("vga_pixel_fetch: RAM_LATENCY must be 1..4 and ADDR_WIDTH must cover the framebuffer");
  end

  assign act    = hcount < 10'(SCREEN_WIDTH) && vcount < 10'(SCREEN_HEIGHT);
  assign fstart = hcount == 10'd0 && vcount == 10'd0;
  assign last   = hcount == 10'(SCREEN_WIDTH - 1) && vcount == 10'(SCREEN_HEIGHT - 1);
  // At frame start the state is about to change, so enable decides whether this frame is shown.
  assign live   = act && (fstart ? enable : state != IDLE);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (fstart) state <= enable ? RUN : IDLE;
    else if (state == RUN && !enable) state <= STOP;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) addr <= '0;
    else if (live) addr <= ADDR_WIDTH'(vcount >> SCALE_SHIFT) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(hcount >> SCALE_SHIFT);
  end

  if (DATA_WIDTH == 16) begin : g_rgb565
    assign r8 = {data[15:11], data[15:13]};
    assign g8 = {data[10:5], data[10:9]};
    assign b8 = {data[4:0], data[4:2]};
  end else begin : g_rgb888
    assign r8 = data[23:16];
    assign g8 = data[15:8];
    assign b8 = data[7:0];
  end

  // vpipe[RAM_LATENCY] lines up with data; lpipe carries one extra stage so frame_done follows the last pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe      <= '0;
      lpipe      <= '0;
      pix_valid  <= 1'b0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      frame_done <= 1'b0;
    end else begin
      vpipe      <= {vpipe[RAM_LATENCY-1:0], live};
      lpipe      <= {lpipe[RAM_LATENCY:0], live && last};
      pix_valid  <= vpipe[RAM_LATENCY];
      vga_r      <= vpipe[RAM_LATENCY] ? r8[7 -: COLOR_DEPTH] : '0;
      vga_g      <= vpipe[RAM_LATENCY] ? g8[7 -: COLOR_DEPTH] : '0;
      vga_b      <= vpipe[RAM_LATENCY] ? b8[7 -: COLOR_DEPTH] : '0;
      frame_done <= lpipe[RAM_LATENCY+1];
    end
  end
endmodule
